// File: rtl/fqmul_pipe.sv
// fqmul_pipe: streaming (a*b) mod 3329 using a 3-stage Barrett reduction (k=32).
// A single global advance enable stalls every stage together, so a tag stays aligned with its data.
module fqmul_pipe #(
  parameter logic [15:0] Q    = 16'd3329,
  parameter logic [31:0] MU   = 32'h13AFB7,
  parameter int          TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_a,
  input  logic [15:0]     in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_r,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  logic [31:0]     r_c1;
  logic [TAGW-1:0] r_tag1;
  logic            r_v1;
  logic [31:0]     r_c2;
  logic [31:0]     r_t2;
  logic [TAGW-1:0] r_tag2;
  logic            r_v2;
  logic [15:0]     r_out_r;
  logic [TAGW-1:0] r_out_tag;
  logic            r_out_valid;

  logic            w_adv;
  logic [31:0]     w_c;
  logic [63:0]     w_prod;
  logic [31:0]     w_t;
  logic [31:0]     w_d;
  logic [31:0]     w_r;

  assign w_adv  = ~(r_out_valid & ~out_ready);
  assign w_c    = 32'(in_a) * 32'(in_b);
  assign w_prod = 64'(r_c1) * 64'(MU);
  assign w_t    = 32'(w_prod >> 32);
  // Modular wrap in 32 bits is harmless: the true difference is known to lie in [0, 2Q).
  assign w_d    = r_c2 - r_t2 * 32'(Q);
  assign w_r    = (w_d >= 32'(Q)) ? (w_d - 32'(Q)) : w_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_tag   <= '0;
    end else if (w_adv) begin
      r_c1        <= w_c;
      r_tag1      <= in_tag;
      r_v1        <= in_valid;
      r_c2        <= r_c1;
      r_t2        <= w_t;
      r_tag2      <= r_tag1;
      r_v2        <= r_v1;
      // Bubbles reach the output as zeros so stale datapath values never show on out_r.
      r_out_r     <= r_v2 ? 16'(w_r) : '0;
      r_out_tag   <= r_v2 ? r_tag2 : '0;
      r_out_valid <= r_v2;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_tag   = r_out_tag;
  assign busy      = r_v1 | r_v2 | r_out_valid;

endmodule
